ls_unit: RTL and testbench

- Multicycle load/store sequencer that sits between the datapath and the word-addressed data memory.
- Loads: issues an aligned word read, extracts the byte or half lane selected by addr[1:0] (little-endian), and zero- or sign-extends it.
- Stores: SW is a single write. SB/SH run a read-modify-write sequence so the other lanes are preserved.
- Size encoding: 00 none, 01 byte, 10 half, 11 word. This extends the existing LB/LH/LW size control with offset, sign and store support.

---
 rtl/ls_pkg.sv | 21 ++
 rtl/ls_lane_extract.sv | 36 +++
 rtl/ls_unit.sv | 147 ++++++++++++++
 tb/tb_ls_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared size encodings, FSM state type and lane width for the load/store sequencer.
package ls_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] LS_NONE = 2'b00;
  localparam logic [1:0] LS_BYTE = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;
  localparam logic [1:0] LS_WORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CAPTURE,
    MERGE,
    WRITE,
    FIN
  } ls_state_t;

endpackage

// File: rtl/ls_lane_extract.sv
// Picks the byte/half/word lane of a little-endian memory word and zero- or sign-extends it.
module ls_lane_extract
  import ls_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  logic signed [LANE_W-1:0]   byte_lane;
  logic signed [2*LANE_W-1:0] half_lane;

  always_comb begin
    byte_lane = data[7:0];
    case (offset)
      2'd1:    byte_lane = data[15:8];
      2'd2:    byte_lane = data[23:16];
      2'd3:    byte_lane = data[31:24];
      default: byte_lane = data[7:0];
    endcase
    // addr[0] plays no part in half selection
    half_lane = offset[1] ? data[31:16] : data[15:0];

    result = data;
    case (size)
      LS_BYTE: result = sign_ext ? DATA_W'(byte_lane) : DATA_W'($unsigned(byte_lane));
      LS_HALF: result = sign_ext ? DATA_W'(half_lane) : DATA_W'($unsigned(half_lane));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/ls_unit.sv
// Multicycle load/store sequencer with read-modify-write for sub-word stores.
// Optional misalignment trap enabled by defining LS_MISALIGN_TRAP_EN.
module ls_unit
  import ls_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] load_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("ls_unit: DATA_W must be 32");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_mem_lat
    $error("ls_unit: MEM_LAT must be in 1..4");
  end

  ls_state_t         state, nxt;
  logic [2:0]        wait_cnt;
  logic              mis_q;
  logic              misalign;
  logic [1:0]        req_off;
  logic [1:0]        req_size;
  logic              req_sign;
  logic              req_store;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] extracted;

`ifdef LS_MISALIGN_TRAP_EN
  assign misalign = ((size == LS_HALF) && addr[0]) ||
                    ((size == LS_WORD) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        off,
    input logic [1:0]        sz,
    input logic [DATA_W-1:0] src
  );
    logic [DATA_W-1:0] r;
    r = word;
    if (sz == LS_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = src[7:0];
        2'd1:    r[15:8]  = src[7:0];
        2'd2:    r[23:16] = src[7:0];
        default: r[31:24] = src[7:0];
      endcase
    end else if (sz == LS_HALF) begin
      if (off[1]) r[31:16] = src[15:0];
      else        r[15:0]  = src[15:0];
    end
    return r;
  endfunction

  ls_lane_extract #(.DATA_W(DATA_W)) u_extract (
    .data     (mem_rdata),
    .offset   (req_off),
    .size     (req_size),
    .sign_ext (req_sign),
    .result   (extracted)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (size == LS_NONE || misalign)      nxt = FIN;
          else if (is_store && size == LS_WORD) nxt = WRITE;
          else                                  nxt = RD_REQ;
        end
      end
      RD_REQ:  nxt = RD_WAIT;
      // RD_WAIT lasts MEM_LAT cycles so mem_rdata is settled on entry to CAPTURE/MERGE
      RD_WAIT: if (wait_cnt == 3'(MEM_LAT - 1)) nxt = req_store ? MERGE : CAPTURE;
      CAPTURE: nxt = FIN;
      MERGE:   nxt = WRITE;
      WRITE:   nxt = FIN;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == FIN);
  assign err    = done && mis_q;
  assign mem_wr = (state == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mis_q     <= 1'b0;
      load_data <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mis_q <= misalign;
            if (nxt != FIN) mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            if (nxt == WRITE) mem_wdata <= store_data;
          end
        end
        RD_REQ:  wait_cnt  <= '0;
        RD_WAIT: wait_cnt  <= wait_cnt + 3'd1;
        CAPTURE: load_data <= extracted;
        MERGE:   mem_wdata <= lane_merge(mem_rdata, req_off, req_size, req_data);
        default: ;
      endcase
    end
  end

  // Request fields are only consumed while busy, so they carry no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      req_off   <= addr[1:0];
      req_size  <= size;
      req_sign  <= sign_ext;
      req_store <= is_store;
      req_data  <= store_data;
    end
  end

endmodule

// File: tb/tb_ls_unit.sv
// Directed bench for ls_unit: one MEM_LAT=1 and one MEM_LAT=3 instance share the stimulus.
module tb_ls_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;

  logic        busy1, done1, err1, mem_wr1;
  logic [31:0] load_data1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        busy3, done3, err3, mem_wr3;
  logic [31:0] load_data3, mem_addr3, mem_wdata3, mem_rdata3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ls_unit #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .store_data(store_data), .busy(busy1),
    .done(done1), .err(err1), .load_data(load_data1), .mem_addr(mem_addr1),
    .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  ls_unit #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .store_data(store_data), .busy(busy3),
    .done(done3), .err(err3), .load_data(load_data3), .mem_addr(mem_addr3),
    .mem_wr(mem_wr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  // Memory models with 1- and 3-cycle read pipelines
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  logic [31:0] r1, p0, p1, p2;
  int wr_cnt1 = 0;
  int done_cnt1 = 0;

  always @(posedge clk) begin
    if (poke_en) begin
      mem1[poke_idx] <= poke_val;
      mem3[poke_idx] <= poke_val;
    end
    if (mem_wr1) mem1[mem_addr1[5:2]] <= mem_wdata1;
    if (mem_wr3) mem3[mem_addr3[5:2]] <= mem_wdata3;
    r1 <= mem1[mem_addr1[5:2]];
    p0 <= mem3[mem_addr3[5:2]];
    p1 <= p0;
    p2 <= p1;
    if (mem_wr1) wr_cnt1 <= wr_cnt1 + 1;
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  assign mem_rdata1 = r1;
  assign mem_rdata3 = p2;

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issues one request; latencies count cycles after the start-sampling edge (99 = never)
  task automatic run_op(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat1, output int lat3, output int wrc1,
                        output logic [31:0] ld1, output logic [31:0] ld3, output logic e1);
    @(negedge clk);
    is_store = st; size = sz; sign_ext = sg; addr = a; store_data = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = 99; lat3 = 99; wrc1 = 0; ld1 = '0; ld3 = '0; e1 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_wr1 && wrc1 == 0) wrc1 = c;
      if (done1 && lat1 == 99) begin lat1 = c; ld1 = load_data1; e1 = err1; end
      if (done3 && lat3 == 99) begin lat3 = c; ld3 = load_data3; end
      if (lat1 != 99 && lat3 != 99) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err1); end
    total++; if (mem_wr1 !== 1'b0) begin bad++; $display("FAIL rst_mem_wr got=%b want=0", mem_wr1); end
    total++; if (mem_addr1 !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr1); end
    total++; if (mem_wdata1 !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata1); end
    total++; if (load_data1 !== 32'h0) begin bad++; $display("FAIL rst_load_data got=%h want=0", load_data1); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    int l1, l3, w;
    logic [31:0] d1, d3;
    logic e;
    poke(4'd1, 32'h80FF7F01);
    run_op(1'b0, 2'b01, 1'b1, 32'h07, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'hFFFFFF80) begin bad++; $display("FAIL lb3_sx got=%h want=FFFFFF80", d1); end
    total++; if (l1 !== 4) begin bad++; $display("FAIL lb_lat1 got=%0d want=4", l1); end
    total++; if (d3 !== 32'hFFFFFF80) begin bad++; $display("FAIL lb3_sx_lat3 got=%h want=FFFFFF80", d3); end
    total++; if (l3 !== 6) begin bad++; $display("FAIL lb_lat3 got=%0d want=6", l3); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL lb_err got=%b want=0", e); end
    run_op(1'b0, 2'b01, 1'b0, 32'h07, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'h00000080) begin bad++; $display("FAIL lb3_zx got=%h want=00000080", d1); end
    run_op(1'b0, 2'b01, 1'b1, 32'h05, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'h0000007F) begin bad++; $display("FAIL lb1_sx got=%h want=0000007F", d1); end
    run_op(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'h000000FF) begin bad++; $display("FAIL lb2_zx got=%h want=000000FF", d1); end
    total++; if (d3 !== 32'h000000FF) begin bad++; $display("FAIL lb2_zx_lat3 got=%h want=000000FF", d3); end
  endtask

  task automatic test_load_half_word();
    int l1, l3, w;
    logic [31:0] d1, d3;
    logic e;
    poke(4'd2, 32'h8001ABCD);
    run_op(1'b0, 2'b10, 1'b1, 32'h0A, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'hFFFF8001) begin bad++; $display("FAIL lh2_sx got=%h want=FFFF8001", d1); end
    total++; if (d3 !== 32'hFFFF8001) begin bad++; $display("FAIL lh2_sx_lat3 got=%h want=FFFF8001", d3); end
    run_op(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'h0000ABCD) begin bad++; $display("FAIL lh0_zx got=%h want=0000ABCD", d1); end
    run_op(1'b0, 2'b10, 1'b1, 32'h08, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'hFFFFABCD) begin bad++; $display("FAIL lh0_sx got=%h want=FFFFABCD", d1); end
    run_op(1'b0, 2'b11, 1'b1, 32'h08, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'h8001ABCD) begin bad++; $display("FAIL lw got=%h want=8001ABCD", d1); end
    total++; if (l1 !== 4) begin bad++; $display("FAIL lw_lat1 got=%0d want=4", l1); end
    total++; if (mem_addr1 !== 32'h08) begin bad++; $display("FAIL lw_mem_addr got=%h want=00000008", mem_addr1); end
  endtask

  task automatic test_store_rmw();
    int l1, l3, w, w0;
    logic [31:0] d1, d3;
    logic e;
    poke(4'd3, 32'h11223344);
    w0 = wr_cnt1;
    run_op(1'b1, 2'b01, 1'b0, 32'h0D, 32'hFFFFFFAA, l1, l3, w, d1, d3, e);
    total++; if (mem_wdata1 !== 32'h1122AA44) begin bad++; $display("FAIL sb_wdata got=%h want=1122AA44", mem_wdata1); end
    total++; if (mem1[3] !== 32'h1122AA44) begin bad++; $display("FAIL sb_mem got=%h want=1122AA44", mem1[3]); end
    total++; if (mem3[3] !== 32'h1122AA44) begin bad++; $display("FAIL sb_mem_lat3 got=%h want=1122AA44", mem3[3]); end
    total++; if (wr_cnt1 - w0 !== 1) begin bad++; $display("FAIL sb_wr_pulses got=%0d want=1", wr_cnt1 - w0); end
    total++; if (w !== 4) begin bad++; $display("FAIL sb_wr_cycle got=%0d want=4", w); end
    total++; if (l1 !== 5) begin bad++; $display("FAIL sb_lat1 got=%0d want=5", l1); end
    total++; if (l3 !== 7) begin bad++; $display("FAIL sb_lat3 got=%0d want=7", l3); end
    poke(4'd4, 32'h11223344);
    run_op(1'b1, 2'b10, 1'b0, 32'h12, 32'h1234BEEF, l1, l3, w, d1, d3, e);
    total++; if (mem_wdata1 !== 32'hBEEF3344) begin bad++; $display("FAIL sh_wdata got=%h want=BEEF3344", mem_wdata1); end
    total++; if (mem3[4] !== 32'hBEEF3344) begin bad++; $display("FAIL sh_mem_lat3 got=%h want=BEEF3344", mem3[4]); end
    total++; if (mem_addr1 !== 32'h10) begin bad++; $display("FAIL sh_mem_addr got=%h want=00000010", mem_addr1); end
  endtask

  task automatic test_sw_none();
    int l1, l3, w, w0;
    logic [31:0] d1, d3, ldb;
    logic e;
    w0 = wr_cnt1;
    run_op(1'b1, 2'b11, 1'b0, 32'h14, 32'hDEADBEEF, l1, l3, w, d1, d3, e);
    total++; if (l1 !== 2) begin bad++; $display("FAIL sw_lat1 got=%0d want=2", l1); end
    total++; if (l3 !== 2) begin bad++; $display("FAIL sw_lat3 got=%0d want=2", l3); end
    total++; if (w !== 1) begin bad++; $display("FAIL sw_wr_cycle got=%0d want=1", w); end
    total++; if (mem1[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h want=DEADBEEF", mem1[5]); end
    total++; if (wr_cnt1 - w0 !== 1) begin bad++; $display("FAIL sw_wr_pulses got=%0d want=1", wr_cnt1 - w0); end
    ldb = load_data1;
    w0 = wr_cnt1;
    run_op(1'b0, 2'b00, 1'b1, 32'h07, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (l1 !== 1) begin bad++; $display("FAIL none_lat1 got=%0d want=1", l1); end
    total++; if (l3 !== 1) begin bad++; $display("FAIL none_lat3 got=%0d want=1", l3); end
    total++; if (d1 !== ldb) begin bad++; $display("FAIL none_load_data got=%h want=%h", d1, ldb); end
    total++; if (wr_cnt1 - w0 !== 0) begin bad++; $display("FAIL none_wr_pulses got=%0d want=0", wr_cnt1 - w0); end
  endtask

  task automatic test_start_held();
    int d0, seen;
    poke(4'd7, 32'hCAFE12F0);
    d0 = done_cnt1;
    seen = 0;
    @(negedge clk);
    is_store = 1'b0; size = 2'b01; sign_ext = 1'b1; addr = 32'h1C; start = 1'b1;
    @(posedge clk); #1;
    addr = 32'h1D; size = 2'b11; sign_ext = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (done1) begin seen = c; start = 1'b0; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++; if (seen !== 4) begin bad++; $display("FAIL held_lat got=%0d want=4", seen); end
    total++; if (load_data1 !== 32'hFFFFFFF0) begin bad++; $display("FAIL held_load_data got=%h want=FFFFFFF0", load_data1); end
    repeat (10) @(posedge clk);
    #1;
    total++; if (done_cnt1 - d0 !== 1) begin bad++; $display("FAIL held_done_pulses got=%0d want=1", done_cnt1 - d0); end
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL held_idle got=%b want=0", busy1); end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    poke(4'd6, 32'h55667788);
    w0 = wr_cnt1;
    d0 = done_cnt1;
    @(negedge clk);
    is_store = 1'b1; size = 2'b01; sign_ext = 1'b0; addr = 32'h19; store_data = 32'h000000AB;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy1); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy1); end
    total++; if (mem_wr1 !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_wr got=%b want=0", mem_wr1); end
    total++; if (mem_addr1 !== 32'h0) begin bad++; $display("FAIL mid_rst_mem_addr got=%h want=0", mem_addr1); end
    total++; if (mem_wdata1 !== 32'h0) begin bad++; $display("FAIL mid_rst_mem_wdata got=%h want=0", mem_wdata1); end
    total++; if (load_data1 !== 32'h0) begin bad++; $display("FAIL mid_rst_load_data got=%h want=0", load_data1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", done1); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (wr_cnt1 - w0 !== 0) begin bad++; $display("FAIL mid_wr_pulses got=%0d want=0", wr_cnt1 - w0); end
    total++; if (done_cnt1 - d0 !== 0) begin bad++; $display("FAIL mid_done_pulses got=%0d want=0", done_cnt1 - d0); end
    total++; if (mem1[6] !== 32'h55667788) begin bad++; $display("FAIL mid_mem got=%h want=55667788", mem1[6]); end
  endtask

  task automatic test_misalign();
    int l1, l3, w, w0;
    logic [31:0] d1, d3, ldb;
    logic e;
    ldb = load_data1;
    w0 = wr_cnt1;
    run_op(1'b0, 2'b10, 1'b1, 32'h09, 32'h0, l1, l3, w, d1, d3, e);
`ifdef LS_MISALIGN_TRAP_EN
    total++; if (l1 !== 1) begin bad++; $display("FAIL mis_lat1 got=%0d want=1", l1); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", e); end
    total++; if (d1 !== ldb) begin bad++; $display("FAIL mis_load_data got=%h want=%h", d1, ldb); end
    total++; if (wr_cnt1 - w0 !== 0) begin bad++; $display("FAIL mis_wr_pulses got=%0d want=0", wr_cnt1 - w0); end
`else
    total++; if (l1 !== 4) begin bad++; $display("FAIL mis_lat1 got=%0d want=4", l1); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL mis_err got=%b want=0", e); end
    total++; if (d1 !== 32'hFFFFABCD) begin bad++; $display("FAIL mis_load_data got=%h want=FFFFABCD (was %h)", d1, ldb); end
    total++; if (wr_cnt1 - w0 !== 0) begin bad++; $display("FAIL mis_wr_pulses got=%0d want=0", wr_cnt1 - w0); end
    run_op(1'b0, 2'b11, 1'b0, 32'h0B, 32'h0, l1, l3, w, d1, d3, e);
    total++; if (d1 !== 32'h8001ABCD) begin bad++; $display("FAIL mis_lw got=%h want=8001ABCD", d1); end
`endif
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_half_word();
    test_store_rmw();
    test_sw_none();
    test_start_held();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
